spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- Datapath core of the SPI master: programmable tick divider plus a parallel-in/serial-out transmit register and a serial-in/parallel-out receive register.
- Driven by the SPI control FSM, which enables the divider, consumes its tick, and issues load, shift and clear strobes.
- Contains no protocol state. Ordering is only LSB/MSB selection.

Parameters:
- WIDTH, 32, shift-register and data-word width in bits.
- DIV_WIDTH, 8, width of the divide value and the divider counter.

Ports:
- CLK100MHZ  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- divide  input  DIV_WIDTH  tick period minus one.
- count_enable  input  1  runs the divider when high.
- count_end  output  1  divider tick.
- lsb_first  input  1  1 = LSB-first shifting, 0 = MSB-first.
- data_load  input  1  shared shift strobe for the TX and RX registers.
- tx_write  input  1  parallel load of the TX register.
- tx_data  input  WIDTH  parallel TX word.
- sdo  output  1  serial output, registered.
- rx_clear  input  1  clears the RX register.
- sdi  input  1  serial input.
- rx_data  output  WIDTH  parallel RX word, registered.

Behaviour:
- Reset (sync, high): divider counter=0, TX shift register=0, sdo=0, rx_data=0. count_end is 0 while reset is high.
- Divider, count_enable=0: counter forced to 0; count_end=0.
- Divider, count_enable=1: counter increments each cycle. When counter==divide it wraps to 0 next cycle.
- count_end is combinational: count_enable && (counter==divide). This gives a 1-cycle pulse every divide+1 cycles.
- First count_end arrives divide cycles after enable rises, i.e. on the (divide+1)th enabled cycle.
- divide=0 → count_end high every enabled cycle.
- divide changed mid-count: compare uses the live value. If counter>divide, the counter keeps incrementing, wraps at 2^DIV_WIDTH, and then hits divide.
- TX, tx_write=1: TX register<=tx_data; sdo unchanged. tx_write has priority over data_load.
- TX, data_load=1 with tx_write=0, MSB-first: sdo<=reg[WIDTH-1]; reg<=reg<<1 with 0 fill.
- TX, data_load=1 with tx_write=0, LSB-first: sdo<=reg[0]; reg<=reg>>1 with 0 fill.
- The first data_load after a write therefore presents the first bit on sdo. Latency is 1 cycle from strobe to sdo.
- RX, rx_clear=1: rx_data<=0. rx_clear has priority over data_load.
- RX, data_load=1 with rx_clear=0, MSB-first: rx_data<={rx_data[WIDTH-2:0],sdi}.
- RX, data_load=1 with rx_clear=0, LSB-first: rx_data<={sdi,rx_data[WIDTH-1:1]}.
- Short LSB-first transfers are left-justified: N bits land in rx_data[WIDTH-1:WIDTH-N].
- lsb_first is sampled on each strobe. Changing it mid-word is legal but gives mixed ordering; the FSM must hold it stable per word.
- Reset mid-transfer aborts immediately to reset values; no partial word is preserved.
- data_load with neither write nor clear while registers are 0 still shifts, and 0 is shifted out.

Optional Feature:
- Macro SPI_SHIFT_LOOPBACK_EN.
- When defined: RX shift input is taken from the TX register's outgoing bit (the value being loaded into sdo) instead of sdi. sdi is ignored. A full WIDTH-strobe transfer then returns tx_data in rx_data for either bit order.
- When undefined: RX samples the sdi port as specified above.

Decomposition:
- Package spi_shift_pkg:
  - localparams SPI_WORD_WIDTH=32 and SPI_DIV_WIDTH=8.
  - typedef enum logic {MSB_FIRST=0, LSB_FIRST=1} bit_order_t.
- One sub-module: spi_tick_divider (counter + compare, parameterised by DIV_WIDTH).
- Both shift registers are coded inline in the top.

Test Plan:
- Divider: divide=3, count_enable held 1 for 12 cycles → count_end high on enabled cycles 4, 8, 12. Deassert enable → count_end=0 and counter back to 0.
- Divider: divide=0 → count_end high every enabled cycle. Reset asserted mid-count → next tick comes divide+1 cycles after reset release.
- TX MSB-first: tx_write with tx_data=0xA5000000, then 8 data_load pulses → sdo sequence 1,0,1,0,0,1,0,1. Further pulses → 0.
- TX LSB-first: tx_write with 0x000000A5, then 8 pulses → sdo 1,0,1,0,0,1,0,1. tx_write and data_load together → loads, sdo holds.
- RX: rx_clear, then 8 pulses with sdi=1,1,0,0,1,0,1,0, MSB-first → rx_data=0x000000CA. LSB-first → rx_data=0x53000000. rx_clear together with data_load → 0.
- With SPI_SHIFT_LOOPBACK_EN: tx_write 0xDEADBEEF, rx_clear, 32 pulses → rx_data=0xDEADBEEF in both orders.

Source files
------------

// File: rtl/spi_shift_pkg.sv
// spi_shift_pkg -- shared definitions for the SPI shift datapath.
//   SPI_WORD_WIDTH : default data-word / shift-register width
//   SPI_DIV_WIDTH  : default width of the tick divider
//   bit_order_t    : serial bit ordering selected by lsb_first
package spi_shift_pkg;
   localparam int SPI_WORD_WIDTH = 32;
   localparam int SPI_DIV_WIDTH  = 8;

   typedef enum logic {
      MSB_FIRST = 1'b0,
      LSB_FIRST = 1'b1
   } bit_order_t;
endpackage

// File: rtl/spi_tick_divider.sv
// spi_tick_divider -- programmable tick generator for the SPI shift engine.
// Counts enabled cycles and pulses count_end once every divide+1 cycles.
// Ports:
//   CLK100MHZ    in  system clock, rising edge
//   reset        in  synchronous, active-high
//   divide       in  tick period minus one (compared live)
//   count_enable in  runs the counter; low holds the counter at 0
//   count_end    out combinational tick, low while reset is high
module spi_tick_divider
   import spi_shift_pkg::*;
#(
   parameter int DIV_WIDTH = SPI_DIV_WIDTH
) (
   input  logic                 CLK100MHZ,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] divide,
   input  logic                 count_enable,
   output logic                 count_end
);

   logic [DIV_WIDTH-1:0] counter_q, counter_d;
   logic                 at_end;

   // Live compare: if divide drops below the running count, the counter
   // runs on, wraps at 2^DIV_WIDTH and meets the new value on the way up.
   assign at_end = (counter_q == divide);

   always_comb begin
      counter_d = counter_q;
      count_end = count_enable && at_end && !reset;
      if (!count_enable)
         counter_d = '0;
      else if (at_end)
         counter_d = '0;
      else
         counter_d = counter_q + 1'b1;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset)
         counter_q <= '0;
      else
         counter_q <= counter_d;
   end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine -- datapath core of the SPI master: tick divider plus a
// parallel-in/serial-out TX register and a serial-in/parallel-out RX register.
// No protocol state lives here; the control FSM drives all strobes.
// Ports:
//   CLK100MHZ, reset      clock; synchronous active-high reset
//   divide, count_enable  divider control; count_end is the divider tick
//   lsb_first             bit order, sampled on every strobe
//   data_load             shared shift strobe for TX and RX
//   tx_write, tx_data     parallel TX load (wins over data_load)
//   sdo                   registered serial output
//   rx_clear              clears RX (wins over data_load)
//   sdi                   serial input
//   rx_data               registered parallel RX word
// Build option: SPI_SHIFT_LOOPBACK_EN feeds the TX outgoing bit into the RX
// shifter instead of sdi.
module spi_shift_engine
   import spi_shift_pkg::*;
#(
   parameter int WIDTH     = SPI_WORD_WIDTH,
   parameter int DIV_WIDTH = SPI_DIV_WIDTH
) (
   input  logic                 CLK100MHZ,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] divide,
   input  logic                 count_enable,
   output logic                 count_end,
   input  logic                 lsb_first,
   input  logic                 data_load,
   input  logic                 tx_write,
   input  logic [WIDTH-1:0]     tx_data,
   output logic                 sdo,
   input  logic                 rx_clear,
   input  logic                 sdi,
   output logic [WIDTH-1:0]     rx_data
);

   spi_tick_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_div (
      .CLK100MHZ    (CLK100MHZ),
      .reset        (reset),
      .divide       (divide),
      .count_enable (count_enable),
      .count_end    (count_end)
   );

   bit_order_t       order;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic             sdo_q, sdo_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic             tx_out_bit;
   logic             rx_in_bit;

   assign order      = bit_order_t'(lsb_first);
   assign tx_out_bit = (order == LSB_FIRST) ? tx_q[0] : tx_q[WIDTH-1];

`ifdef SPI_SHIFT_LOOPBACK_EN
   // Loop the bit heading for sdo straight back into RX; after WIDTH
   // strobes rx_data holds the transmitted word for either order.
   logic unused_sdi;
   assign unused_sdi = sdi;
   assign rx_in_bit  = tx_out_bit;
`else
   assign rx_in_bit  = sdi;
`endif

   // TX: a write reloads without touching sdo, so the first strobe after a
   // write puts the first bit on the wire.
   always_comb begin
      tx_d  = tx_q;
      sdo_d = sdo_q;
      if (tx_write) begin
         tx_d = tx_data;
      end else if (data_load) begin
         sdo_d = tx_out_bit;
         if (order == LSB_FIRST)
            tx_d = {1'b0, tx_q[WIDTH-1:1]};
         else
            tx_d = {tx_q[WIDTH-2:0], 1'b0};
      end
   end

   // RX: LSB-first shifts in from the top, so short words end up
   // left-justified.
   always_comb begin
      rx_d = rx_q;
      if (rx_clear)
         rx_d = '0;
      else if (data_load) begin
         if (order == LSB_FIRST)
            rx_d = {rx_in_bit, rx_q[WIDTH-1:1]};
         else
            rx_d = {rx_q[WIDTH-2:0], rx_in_bit};
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         tx_q  <= '0;
         sdo_q <= 1'b0;
         rx_q  <= '0;
      end else begin
         tx_q  <= tx_d;
         sdo_q <= sdo_d;
         rx_q  <= rx_d;
      end
   end

   assign sdo     = sdo_q;
   assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine -- directed checks of the divider, TX and RX shifters.
module tb_spi_shift_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  divide;
   logic        count_enable;
   logic        count_end;
   logic        lsb_first;
   logic        data_load;
   logic        tx_write;
   logic [31:0] tx_data;
   logic        sdo;
   logic        rx_clear;
   logic        sdi;
   logic [31:0] rx_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_shift_engine #(.WIDTH(32), .DIV_WIDTH(8)) dut (
      .CLK100MHZ    (clk),
      .reset        (reset),
      .divide       (divide),
      .count_enable (count_enable),
      .count_end    (count_end),
      .lsb_first    (lsb_first),
      .data_load    (data_load),
      .tx_write     (tx_write),
      .tx_data      (tx_data),
      .sdo          (sdo),
      .rx_clear     (rx_clear),
      .sdi          (sdi),
      .rx_data      (rx_data)
   );

   typedef struct {
      logic        tx_write;
      logic        data_load;
      logic        rx_clear;
      logic        lsb_first;
      logic        sdi;
      logic [31:0] tx_data;
      logic        exp_sdo;
      logic [31:0] exp_rx;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic w, logic dl, logic clr, logic lsb, logic si,
                               logic [31:0] td, logic es, logic [31:0] er);
      vec_t v;
      v.tx_write = w;   v.data_load = dl; v.rx_clear = clr;
      v.lsb_first = lsb; v.sdi = si;      v.tx_data = td;
      v.exp_sdo = es;   v.exp_rx = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tx_write = 0; data_load = 0; rx_clear = 0; sdi = 0; tx_data = '0;
   endtask

   initial begin
      // reset with the divider primed to tick: count_end must stay low
      reset = 1; divide = 8'd0; count_enable = 1; lsb_first = 0;
      idle();
      cyc(); cyc();
      chk("rst_count_end", {31'd0, count_end}, 32'd0);
      chk("rst_sdo", {31'd0, sdo}, 32'd0);
      chk("rst_rx", rx_data, 32'd0);
      count_enable = 0;
      reset = 0;
      cyc();

      // ---------------- divider ----------------
      divide = 8'd3; count_enable = 1; #1;
      for (int k = 1; k <= 12; k++) begin
         chk($sformatf("div3_c%0d", k), {31'd0, count_end}, {31'd0, (k % 4 == 0)});
         cyc();
      end
      cyc(); cyc();               // counter now at 2
      count_enable = 0; #1;
      chk("div_disable", {31'd0, count_end}, 32'd0);
      cyc();
      count_enable = 1; #1;       // counter must have restarted from 0
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("div_reen_c%0d", k), {31'd0, count_end}, {31'd0, (k == 4)});
         cyc();
      end
      count_enable = 0; cyc();
      divide = 8'd0; count_enable = 1; #1;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("div0_c%0d", k), {31'd0, count_end}, 32'd1);
         cyc();
      end
      divide = 8'd3; #1;
      cyc(); cyc();               // counter at 2
      reset = 1; #1;
      chk("div_in_reset", {31'd0, count_end}, 32'd0);
      cyc();
      reset = 0; #1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("div_postrst_c%0d", k), {31'd0, count_end}, {31'd0, (k == 4)});
         cyc();
      end
      // live divide drop below running count: wraps through 255
      count_enable = 0; cyc();
      divide = 8'd200; count_enable = 1; #1;
      for (int k = 0; k < 6; k++) cyc();   // counter = 6
      divide = 8'd2; #1;
      begin
         int n;
         n = 0;
         while (!count_end && n < 400) begin
            cyc();
            n++;
         end
         chk("div_wrap_cycles", n, 252);
      end
      count_enable = 0;
      cyc();

`ifndef SPI_SHIFT_LOOPBACK_EN
      // ---------------- TX / RX vector table ----------------
      //              wr dl clr lsb sdi tx_data        sdo rx
      vecs.push_back(mk(1, 0, 0, 0, 0, 32'hA500_0000, 0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0000_00A5, 0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 32'h0));
      // write + strobe together: load wins, sdo holds its 1
      vecs.push_back(mk(1, 1, 0, 0, 0, 32'h8000_0000, 1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0));
      // RX MSB-first, sdi = 1,1,0,0,1,0,1,0
      vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,         0, 32'h01));
      vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,         0, 32'h03));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h06));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0C));
      vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,         0, 32'h19));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h32));
      vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,         0, 32'h65));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'hCA));
      // clear + strobe together: clear wins
      vecs.push_back(mk(0, 1, 1, 0, 1, 32'h0,         0, 32'h0));
      // RX LSB-first, same bits, left-justified
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0,         0, 32'h8000_0000));
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0,         0, 32'hC000_0000));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h6000_0000));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h3000_0000));
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0,         0, 32'h9800_0000));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h4C00_0000));
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0,         0, 32'hA600_0000));
      vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         0, 32'h5300_0000));

      foreach (vecs[i]) begin
         tx_write  = vecs[i].tx_write;
         data_load = vecs[i].data_load;
         rx_clear  = vecs[i].rx_clear;
         lsb_first = vecs[i].lsb_first;
         sdi       = vecs[i].sdi;
         tx_data   = vecs[i].tx_data;
         cyc();
         chk($sformatf("vec%0d_sdo", i), {31'd0, sdo}, {31'd0, vecs[i].exp_sdo});
         chk($sformatf("vec%0d_rx", i), rx_data, vecs[i].exp_rx);
      end
      idle();
      cyc();
`else
      // ---------------- loopback: word returns in both orders ----------------
      for (int o = 0; o < 2; o++) begin
         lsb_first = o[0];
         tx_write = 1; tx_data = 32'hDEAD_BEEF; rx_clear = 1;
         cyc();
         idle();
         data_load = 1;
         for (int b = 0; b < 32; b++) cyc();
         data_load = 0;
         chk($sformatf("loopback_o%0d", o), rx_data, 32'hDEAD_BEEF);
         cyc();
      end
`endif

      // ---------------- reset mid-transfer ----------------
      lsb_first = 0;
      tx_write = 1; tx_data = 32'hFFFF_FFFF; rx_clear = 1;
      cyc();
      idle();
      data_load = 1; sdi = 1;
      cyc();
      chk("mid_sdo", {31'd0, sdo}, 32'd1);
      reset = 1;
      cyc();
      chk("abort_sdo", {31'd0, sdo}, 32'd0);
      chk("abort_rx", rx_data, 32'd0);
      reset = 0; sdi = 0;
      cyc();
      // TX was wiped, so only zeros come out
      chk("post_abort_sdo", {31'd0, sdo}, 32'd0);
      chk("post_abort_rx", rx_data, 32'd0);
      idle();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
